// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default constants and width helpers for the PWM duty-cycle control slice.
package pwm_ctrl_pkg;

    // Per-button auto-repeat state.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHeld   = 2'd1,
        StRepeat = 2'd2
    } btn_state_t;

    // Default duty configuration: 0..10 in 10% steps, mid-scale after reset.
    localparam int unsigned DEFAULT_DUTY_W    = 4;
    localparam int unsigned DEFAULT_DUTY_MAX  = 10;
    localparam int unsigned DEFAULT_DUTY_INIT = 5;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a counter holding 0..value-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned value);
        int unsigned w;
        w = clog2(value);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce_rpt.sv
// One push-button channel: 2-FF synchroniser, tick-sampled debounce and a press/hold
// auto-repeat FSM that emits single-cycle step requests.
module btn_debounce_rpt
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 2,
    parameter int unsigned REPEAT_DELAY   = 10,
    parameter int unsigned REPEAT_RATE    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic step_o
);

    localparam int unsigned StbW   = cnt_width(STABLE_SAMPLES);
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RptW   = cnt_width(RptMax);

    localparam logic [StbW-1:0] StbLast   = StbW'(STABLE_SAMPLES - 1);
    localparam logic [RptW-1:0] DelayLast = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RateLast  = RptW'(REPEAT_RATE - 1);

    logic            sync1_q, sync2_q;
    logic            db_d, db_q;
    logic [StbW-1:0] stb_d, stb_q;
    btn_state_t      state_d, state_q;
    logic [RptW-1:0] rpt_d, rpt_q;
    logic            rise, fall;

    // Two-stage synchroniser for the asynchronous raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level must disagree on STABLE_SAMPLES consecutive ticks to flip.
    always_comb begin
        db_d  = db_q;
        stb_d = stb_q;
        if (tick_i) begin
            if (sync2_q == db_q) begin
                stb_d = '0;
            end else if (stb_q == StbLast) begin
                db_d  = ~db_q;
                stb_d = '0;
            end else begin
                stb_d = stb_q + 1'b1;
            end
        end
    end

    assign rise = db_d & ~db_q;
    assign fall = ~db_d & db_q;

    // Level including a flip that lands this cycle, so the top can mask a step
    // issued in the same cycle the second button becomes debounced-high.
    assign level_o = db_d;

    // Press/hold FSM: step on press, after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        step_o  = 1'b0;
        if (fall) begin
            // Release is silent and wins over any repeat due on the same tick.
            state_d = StIdle;
            rpt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StHeld;
                        rpt_d   = '0;
                        step_o  = 1'b1;
                    end
                end
                StHeld: begin
                    if (tick_i) begin
                        if (rpt_q == DelayLast) begin
                            state_d = StRepeat;
                            rpt_d   = '0;
                            step_o  = 1'b1;
                        end else begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
                end
                StRepeat: begin
                    if (tick_i) begin
                        if (rpt_q == RateLast) begin
                            rpt_d  = '0;
                            step_o = 1'b1;
                        end else begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    rpt_d   = '0;
                end
            endcase
        end
    end

    // Debounce and FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_q    <= 1'b0;
            stb_q   <= '0;
            state_q <= StIdle;
            rpt_q   <= '0;
        end else begin
            db_q    <= db_d;
            stb_q   <= stb_d;
            state_q <= state_d;
            rpt_q   <= rpt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle control stage: shared sample-tick prescaler, two button channels,
// request arbitration and the saturating duty register feeding the PWM comparator.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 2500000,
    parameter int unsigned STABLE_SAMPLES = 2,
    parameter int unsigned REPEAT_DELAY   = 10,
    parameter int unsigned REPEAT_RATE    = 4,
    parameter int unsigned DUTY_W         = DEFAULT_DUTY_W,
    parameter int unsigned DUTY_MAX       = DEFAULT_DUTY_MAX,
    parameter int unsigned DUTY_INIT      = DEFAULT_DUTY_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ui_increase_duty,
    input  logic              ui_decrease_duty,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_inc_o,
    output logic              duty_dec_o,
    output logic              at_max_o,
    output logic              at_min_o
);

    localparam int unsigned     TickW    = cnt_width(TICK_DIV);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [DUTY_W-1:0] DutyMax  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DutyInit = DUTY_W'(DUTY_INIT);

    logic [TickW-1:0]  presc_d, presc_q;
    logic              tick;
    logic              inc_level, dec_level;
    logic              inc_step, dec_step;
    logic              inc_req, dec_req;
    logic [DUTY_W-1:0] duty_d, duty_q;
    logic              inc_pulse_d, inc_pulse_q;
    logic              dec_pulse_d, dec_pulse_q;

    // Prescaler: one tick cycle every TICK_DIV clocks (every cycle when TICK_DIV is 1).
    assign tick    = (presc_q == TickLast);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    btn_debounce_rpt #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn_inc (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick),
        .btn_i   (ui_increase_duty),
        .level_o (inc_level),
        .step_o  (inc_step)
    );

    btn_debounce_rpt #(
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn_dec (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick),
        .btn_i   (ui_decrease_duty),
        .level_o (dec_level),
        .step_o  (dec_step)
    );

    // Arbitration: drop coincident requests and mask everything while both buttons are down.
    // The FSMs keep running, so the survivor resumes repeating once the other is released.
    always_comb begin
        inc_req = inc_step & ~dec_step & ~(inc_level & dec_level);
        dec_req = dec_step & ~inc_step & ~(inc_level & dec_level);
    end

    // Saturating duty update with change-indicating pulses.
    always_comb begin
        duty_d      = duty_q;
        inc_pulse_d = 1'b0;
        dec_pulse_d = 1'b0;
        if (inc_req && (duty_q < DutyMax)) begin
            duty_d      = duty_q + 1'b1;
            inc_pulse_d = 1'b1;
        end else if (dec_req && (duty_q != '0)) begin
            duty_d      = duty_q - 1'b1;
            dec_pulse_d = 1'b1;
        end
    end

    // Duty and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q      <= DutyInit;
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            inc_pulse_q <= inc_pulse_d;
            dec_pulse_q <= dec_pulse_d;
        end
    end

    assign duty_o     = duty_q;
    assign duty_inc_o = inc_pulse_q;
    assign duty_dec_o = dec_pulse_q;
    assign at_max_o   = (duty_q == DutyMax);
    assign at_min_o   = (duty_q == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl: directed scenarios with literal expectations plus
// randomized button activity, all checked every cycle against a behavioural model.
module tb_pwm_duty_ctrl;

    localparam int TICK_DIV       = 4;
    localparam int STABLE_SAMPLES = 2;
    localparam int REPEAT_DELAY   = 3;
    localparam int REPEAT_RATE    = 2;
    localparam int DUTY_W         = 4;
    localparam int DUTY_MAX       = 10;
    localparam int DUTY_INIT      = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ui_increase_duty;
    logic              ui_decrease_duty;
    logic [DUTY_W-1:0] duty_o;
    logic              duty_inc_o, duty_dec_o, at_max_o, at_min_o;

    pwm_duty_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .STABLE_SAMPLES (STABLE_SAMPLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE),
        .DUTY_W         (DUTY_W),
        .DUTY_MAX       (DUTY_MAX),
        .DUTY_INIT      (DUTY_INIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ui_increase_duty (ui_increase_duty),
        .ui_decrease_duty (ui_decrease_duty),
        .duty_o           (duty_o),
        .duty_inc_o       (duty_inc_o),
        .duty_dec_o       (duty_dec_o),
        .at_max_o         (at_max_o),
        .at_min_o         (at_min_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per button: synchroniser delay line, debounced level, disagreement run length and
    // number of ticks elapsed since the debounced press.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    int m_run [2];
    int m_held [2];
    int m_pcnt;
    int m_duty;
    bit m_inc, m_dec;
    bit m_raw [2];
    bit m_new [2];
    bit m_req [2];
    bit m_tick;

    always @(posedge clk) begin
        m_raw[0] = ui_increase_duty;
        m_raw[1] = ui_decrease_duty;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_run[b] = 0; m_held[b] = 0;
            end
            m_pcnt = 0;
            m_duty = DUTY_INIT;
            m_inc  = 0;
            m_dec  = 0;
        end else begin
            m_tick = (m_pcnt == TICK_DIV - 1);
            for (int b = 0; b < 2; b++) begin
                m_req[b] = 0;
                m_new[b] = m_db[b];
                if (m_tick) begin
                    if (m_s2[b] == m_db[b]) begin
                        m_run[b] = 0;
                    end else begin
                        m_run[b]++;
                        if (m_run[b] == STABLE_SAMPLES) begin
                            m_new[b] = !m_db[b];
                            m_run[b] = 0;
                        end
                    end
                end
                if (m_new[b] && !m_db[b]) begin
                    m_req[b]  = 1;
                    m_held[b] = 0;
                end else if (m_new[b] && m_db[b] && m_tick) begin
                    m_held[b]++;
                    if (m_held[b] == REPEAT_DELAY ||
                        (m_held[b] > REPEAT_DELAY &&
                         (m_held[b] - REPEAT_DELAY) % REPEAT_RATE == 0))
                        m_req[b] = 1;
                end
            end
            if (m_new[0] && m_new[1]) begin
                m_req[0] = 0;
                m_req[1] = 0;
            end
            m_inc = 0;
            m_dec = 0;
            if (m_req[0] && !m_req[1] && m_duty < DUTY_MAX) begin
                m_duty++;
                m_inc = 1;
            end else if (m_req[1] && !m_req[0] && m_duty > 0) begin
                m_duty--;
                m_dec = 1;
            end
            for (int b = 0; b < 2; b++) begin
                m_db[b] = m_new[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = m_raw[b];
            end
            m_pcnt = m_tick ? 0 : m_pcnt + 1;
        end
    end

    // ---------------- per-cycle compare and pulse monitor ----------------
    bit chk_en = 0;
    int cyc = 0;
    int inc_seen, dec_seen, first_inc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("duty", int'(duty_o), m_duty);
            check("inc_pulse", int'(duty_inc_o), int'(m_inc));
            check("dec_pulse", int'(duty_dec_o), int'(m_dec));
            check("at_max", int'(at_max_o), int'(m_duty == DUTY_MAX));
            check("at_min", int'(at_min_o), int'(m_duty == 0));
            if (duty_inc_o === 1'b1) begin
                inc_seen++;
                if (first_inc_cyc < 0) first_inc_cyc = cyc;
            end
            if (duty_dec_o === 1'b1) dec_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        inc_seen      = 0;
        dec_seen      = 0;
        first_inc_cyc = -1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    int mark;

    initial begin
        rst              = 1'b1;
        ui_increase_duty = 1'b0;
        ui_decrease_duty = 1'b0;
        clr_counts();
        step(3);
        chk_en = 1;
        rst    = 1'b0;

        // Reset values.
        check("rst_duty", int'(duty_o), 5);
        check("rst_inc", int'(duty_inc_o), 0);
        check("rst_dec", int'(duty_dec_o), 0);
        check("rst_at_max", int'(at_max_o), 0);
        check("rst_at_min", int'(at_min_o), 0);
        step(6);

        // Single press held for three ticks: exactly one step, bounded latency.
        clr_counts();
        mark             = cyc;
        ui_increase_duty = 1'b1;
        step(12);
        ui_increase_duty = 1'b0;
        step(24);
        check("press_seen", int'(first_inc_cyc >= 0), 1);
        check("press_latency_ok", int'(first_inc_cyc >= 0 && first_inc_cyc - mark <= 11), 1);
        check("press_pulses", inc_seen, 1);
        check("press_duty", int'(duty_o), 6);

        // One-cycle reset mid-count returns to reset values.
        step(2);
        pulse_reset();
        check("midrst_duty", int'(duty_o), 5);
        check("midrst_inc", int'(duty_inc_o), 0);
        check("midrst_flags", int'({at_max_o, at_min_o}), 0);

        // One-tick glitch is ignored.
        clr_counts();
        ui_increase_duty = 1'b1;
        step(4);
        ui_increase_duty = 1'b0;
        step(16);
        check("glitch_pulses", inc_seen, 0);
        check("glitch_duty", int'(duty_o), 5);

        // Long hold: press, +3, +5, +7, +9 ticks saturate 5 -> 10.
        clr_counts();
        ui_increase_duty = 1'b1;
        step(80);
        check("sat_duty", int'(duty_o), 10);
        check("sat_at_max", int'(at_max_o), 1);
        check("sat_pulses", inc_seen, 5);
        ui_increase_duty = 1'b0;
        step(24);

        // Long decrease hold from 5 reaches 0 and never wraps.
        pulse_reset();
        clr_counts();
        ui_decrease_duty = 1'b1;
        step(80);
        check("floor_duty", int'(duty_o), 0);
        check("floor_at_min", int'(at_min_o), 1);
        check("floor_pulses", dec_seen, 5);
        ui_decrease_duty = 1'b0;
        step(24);

        // Both pressed together: nothing; releasing decrease lets increase repeat resume.
        pulse_reset();
        clr_counts();
        ui_increase_duty = 1'b1;
        ui_decrease_duty = 1'b1;
        step(40);
        check("both_duty", int'(duty_o), 5);
        check("both_pulses", inc_seen + dec_seen, 0);
        ui_decrease_duty = 1'b0;
        step(40);
        check("resume_up", int'(duty_o > 5), 1);
        check("resume_no_dec", dec_seen, 0);
        ui_increase_duty = 1'b0;
        step(24);

        // Randomized button activity with occasional resets; the model checks every cycle.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                pulse_reset();
            end else begin
                ui_increase_duty = ($urandom_range(0, 2) != 0);
                ui_decrease_duty = ($urandom_range(0, 2) == 0);
                step($urandom_range(1, 45));
            end
        end
        ui_increase_duty = 1'b0;
        ui_decrease_duty = 1'b0;
        step(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
- Upstream control stage for the PWM generator.
- Takes the two raw, asynchronous push-button inputs and synchronises and debounces them on a slow sample tick.
- Converts presses, and holds with auto-repeat, into single-cycle step events.
- Keeps the saturating duty-cycle value (0..DUTY_MAX, in 10% steps) that feeds the PWM comparator directly.

Parameters:
- TICK_DIV, 2500000: clk cycles per debounce sample tick (20 Hz at 50 MHz); must be >=1.
- STABLE_SAMPLES, 2: consecutive ticks a synchronised level must hold before the debounced state changes; must be >=1.
- REPEAT_DELAY, 10: ticks a button must be held after the first step before auto-repeat starts.
- REPEAT_RATE, 4: ticks between auto-repeat steps while held.
- DUTY_W, 4: width of the duty value.
- DUTY_MAX, 10: upper saturation value; must be < 2^DUTY_W.
- DUTY_INIT, 5: duty value after reset; must be <= DUTY_MAX.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ui_increase_duty  in  1  raw increase button, asynchronous, active-high.
- ui_decrease_duty  in  1  raw decrease button, asynchronous, active-high.
- duty_o  out  DUTY_W  current duty step (0..DUTY_MAX), registered.
- duty_inc_o  out  1  one-cycle pulse when duty_o actually incremented.
- duty_dec_o  out  1  one-cycle pulse when duty_o actually decremented.
- at_max_o  out  1  duty_o == DUTY_MAX.
- at_min_o  out  1  duty_o == 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - duty_o = DUTY_INIT.
  - duty_inc_o = duty_dec_o = 0.
  - at_max_o and at_min_o reflect DUTY_INIT.
  - Synchronisers, debounced states and stable counters = 0 (released).
  - Prescaler = 0; both button FSMs = IDLE.
- Synchroniser: each raw button passes through a 2-FF synchroniser, every clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when count == TICK_DIV-1.
  - TICK_DIV=1 means tick every cycle.
- Debounce, per button, evaluated only on tick:
  - Synchronised level == debounced state: stable counter clears.
  - Otherwise the counter increments. When it reaches STABLE_SAMPLES, the debounced state flips and the counter clears.
  - Glitches shorter than STABLE_SAMPLES ticks are ignored.
- Button FSM, per button; states IDLE, HELD, REPEAT:
  - IDLE -> HELD on debounced rising edge. Issue a step request in that same cycle.
  - HELD: count ticks. After REPEAT_DELAY ticks -> REPEAT and issue a step request; the rate counter clears.
  - REPEAT: issue a step request every REPEAT_RATE ticks.
  - Any state -> IDLE when the debounced state goes 0. No step request is issued on release.
  - Step requests are one clk cycle wide and only ever coincide with a tick or a debounce flip cycle.
- Duty register:
  - Updated one cycle after a step request; latency step request -> duty_o is 1 clk.
  - inc request with duty_o < DUTY_MAX: duty_o+1, duty_inc_o=1 that cycle.
  - dec request with duty_o > 0: duty_o-1, duty_dec_o=1 that cycle.
  - Request at the limit: duty_o unchanged, no pulse (saturate, never wrap).
  - inc and dec requests in the same cycle: both dropped, no change, no pulse.
  - Both debounced states high: all step requests from both FSMs are suppressed. Each FSM keeps its state; repeat resumes for the button still held once the other is released.
- Reset mid-operation: everything returns to reset values on the next clk edge. A button held through reset is seen as a new press once debounced, giving one step after STABLE_SAMPLES ticks.
- Flags: at_max_o and at_min_o are combinational from duty_o.

Decomposition:
- Package pwm_ctrl_pkg holds:
  - btn_state_t enum: IDLE, HELD, REPEAT.
  - Default constants: DUTY_W, DUTY_MAX, DUTY_INIT.
  - Helper function clog2 for counter widths.
- Sub-module btn_debounce_rpt: synchroniser, debounce counter, FSM and step-request output. Instantiated twice.
- Top level holds the shared prescaler, the arbitration and the duty register.

Test Plan (TICK_DIV=4, STABLE_SAMPLES=2, REPEAT_DELAY=3, REPEAT_RATE=2, DUTY_MAX=10, DUTY_INIT=5):
- Reset release -> duty_o=5, no pulses, at_max_o=at_min_o=0; rst asserted for 1 cycle mid-count -> same values next cycle.
- Increase held 3 ticks then released -> exactly one duty_inc_o pulse, duty_o=6, at most 2+4*2+1 cycles after the raw edge.
- Increase pulsed high for 1 tick only (glitch) -> no pulse, duty_o stays 5.
- Increase held 20 ticks -> one step at press, next at +3 ticks, then every 2 ticks; duty_o saturates at 10 with at_max_o=1; no further duty_inc_o.
- Decrease held from duty_o=1 -> one step to 0, at_min_o=1; further repeats give no pulse and no wrap to 15.
- Both buttons pressed within the same tick -> no change. Release decrease while increase is held -> repeat steps resume on increase only.
